// File: rtl/gpu_trace_pkg.sv
// gpu_trace_pkg: shared definitions for the instruction-trace buffer.
//   - trace_state_e : capture/readout FSM states (3-bit, exported on the state port)
//   - entry field offsets and width helpers for the packed trace entry
//     {oh_err, ch_idx, warp_id, timestamp, pc, instr}
//   - opcode constants used when programming the opcode trigger
package gpu_trace_pkg;

  localparam int unsigned TS_W      = 16;
  localparam int unsigned INSTR_LSB = 0;
  localparam int unsigned PC_LSB    = 32;
  localparam int unsigned TS_LSB    = 64;
  localparam int unsigned WID_LSB   = 80;

  localparam logic [5:0] OPC_EXIT = 6'b100001;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_POST  = 3'd2,
    ST_DONE  = 3'd3,
    ST_READ  = 3'd4
  } trace_state_e;

  // Index width that never collapses to zero bits for single-element ranges.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned entry_w(input int unsigned nch, input int unsigned nw);
    return 1 + idx_w(nch) + idx_w(nw) + TS_W + 64;
  endfunction

endpackage

// File: rtl/inst_trace_buffer_onehot_enc.sv
// onehot_enc: decodes a one-hot warp ID.
//   i_onehot : one-hot (ideally) warp vector
//   o_idx    : index of the lowest set bit (0 when none set)
//   o_valid  : at least one bit set
//   o_err    : more than one bit set
module onehot_enc
  import gpu_trace_pkg::*;
#(
  parameter int unsigned NUM_WARPS = 8
) (
  input  logic [NUM_WARPS-1:0]        i_onehot,
  output logic [idx_w(NUM_WARPS)-1:0] o_idx,
  output logic                        o_valid,
  output logic                        o_err
);

  localparam int unsigned IW = idx_w(NUM_WARPS);

  logic w_found;

  always_comb begin
    o_idx   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      if (i_onehot[i] && !w_found) begin
        o_idx   = IW'(i);
        w_found = 1'b1;
      end
    end
  end

  assign o_valid = |i_onehot;
  // Clearing the lowest set bit leaves something only if a second bit was set.
  assign o_err   = |(i_onehot & (i_onehot - NUM_WARPS'(1)));

endmodule

// File: rtl/inst_trace_buffer.sv
// inst_trace_buffer: on-chip circular instruction-trace capture buffer.
//   clk, rst_n        : clock, asynchronous active-low reset
//   ch_valid/_warp_onehot/_instr/_pc : NUM_CH tapped pipeline stages
//   warp_mask         : per-warp capture enable
//   arm               : start capture (IDLE or DONE)
//   trig_in, trig_en, trig_opcode, trig_opmask : external / opcode trigger
//   rd_start          : start draining a frozen buffer (DONE)
//   rd_valid/rd_ready/rd_data/rd_last : oldest-first readout stream
//   state, count, drop_cnt : status
module inst_trace_buffer
  import gpu_trace_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned NUM_WARPS = 8,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned POST_TRIG = 32
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_CH-1:0]                       ch_valid,
  input  logic [NUM_CH*NUM_WARPS-1:0]             ch_warp_onehot,
  input  logic [NUM_CH*32-1:0]                    ch_instr,
  input  logic [NUM_CH*32-1:0]                    ch_pc,
  input  logic [NUM_WARPS-1:0]                    warp_mask,
  input  logic                                    arm,
  input  logic                                    trig_in,
  input  logic                                    trig_en,
  input  logic [5:0]                              trig_opcode,
  input  logic [5:0]                              trig_opmask,
  input  logic                                    rd_start,
  output logic                                    rd_valid,
  input  logic                                    rd_ready,
  output logic [entry_w(NUM_CH, NUM_WARPS)-1:0]   rd_data,
  output logic                                    rd_last,
  output logic [2:0]                              state,
  output logic [$clog2(DEPTH):0]                  count,
  output logic [15:0]                             drop_cnt
);

  localparam int unsigned CH_W    = idx_w(NUM_CH);
  localparam int unsigned WID_W   = idx_w(NUM_WARPS);
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned ENTRY_W = entry_w(NUM_CH, NUM_WARPS);

  trace_state_e        r_state;
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW-1:0]       r_post_cnt;
  logic [AW:0]         r_count;
  logic [AW:0]         r_rd_rem;
  logic [15:0]         r_drop;
  logic [TS_W-1:0]     r_ts;
  logic [CH_W-1:0]     r_rr;
  logic                r_rd_vld;
  logic                r_rd_last;
  logic [ENTRY_W-1:0]  r_rd_data;
  logic [ENTRY_W-1:0]  r_mem [DEPTH];

  logic [NUM_WARPS-1:0] w_oh   [NUM_CH];
  logic [WID_W-1:0]     w_idx  [NUM_CH];
  logic [NUM_CH-1:0]    w_ohv;
  logic [NUM_CH-1:0]    w_err;
  logic [NUM_CH-1:0]    w_qual;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_oh[c] = ch_warp_onehot[c*NUM_WARPS +: NUM_WARPS];
    onehot_enc #(.NUM_WARPS(NUM_WARPS)) u_enc (
      .i_onehot (w_oh[c]),
      .o_idx    (w_idx[c]),
      .o_valid  (w_ohv[c]),
      .o_err    (w_err[c])
    );
    assign w_qual[c] = ch_valid[c] & w_ohv[c] & (|(w_oh[c] & warp_mask));
  end

  // Round-robin: first qualified channel at or after r_rr wins.
  logic [CH_W-1:0] w_pos;
  logic [CH_W-1:0] w_win;
  logic            w_win_vld;
  logic [3:0]      w_nqual;

  always_comb begin
    w_pos     = '0;
    w_win     = '0;
    w_win_vld = 1'b0;
    w_nqual   = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      w_pos = CH_W'((32'(r_rr) + k) % NUM_CH);
      if (w_qual[w_pos] && !w_win_vld) begin
        w_win_vld = 1'b1;
        w_win     = w_pos;
      end
      if (w_qual[k]) w_nqual = w_nqual + 4'd1;
    end
  end

  logic [31:0]      w_sel_instr;
  logic [31:0]      w_sel_pc;
  logic [WID_W-1:0] w_sel_wid;
  logic             w_sel_err;

  always_comb begin
    w_sel_instr = '0;
    w_sel_pc    = '0;
    w_sel_wid   = '0;
    w_sel_err   = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (CH_W'(c) == w_win) begin
        w_sel_instr = ch_instr[c*32 +: 32];
        w_sel_pc    = ch_pc[c*32 +: 32];
        w_sel_wid   = w_idx[c];
        w_sel_err   = w_err[c];
      end
    end
  end

  logic [ENTRY_W-1:0] w_entry;

  always_comb begin
    w_entry                              = '0;
    w_entry[INSTR_LSB +: 32]             = w_sel_instr;
    w_entry[PC_LSB +: 32]                = w_sel_pc;
    w_entry[TS_LSB +: TS_W]              = r_ts;
    w_entry[WID_LSB +: WID_W]            = w_sel_wid;
    w_entry[WID_LSB + WID_W +: CH_W]     = w_win;
    w_entry[ENTRY_W-1]                   = w_sel_err;
  end

  logic            w_write;
  logic            w_op_hit;
  logic            w_trig;
  logic [16:0]     w_drop_sum;
  logic [CH_W-1:0] w_rr_next;

  assign w_write    = w_win_vld && ((r_state == ST_ARMED) || (r_state == ST_POST));
  assign w_op_hit   = trig_en && (((w_sel_instr[31:26] ^ trig_opcode) & trig_opmask) == 6'd0);
  assign w_trig     = trig_in || (w_write && w_op_hit);
  // Every qualified channel except the winner is a drop.
  assign w_drop_sum = {1'b0, r_drop} + 17'(w_nqual) - 17'd1;
  assign w_rr_next  = (w_win == CH_W'(NUM_CH - 1)) ? '0 : w_win + CH_W'(1);

  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_post_cnt <= '0;
      r_count    <= '0;
      r_rd_rem   <= '0;
      r_drop     <= '0;
      r_ts       <= '0;
      r_rr       <= '0;
      r_rd_vld   <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
      case (r_state)
        ST_IDLE: begin
          if (arm) begin
            r_state  <= ST_ARMED;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_drop   <= '0;
          end
        end
        ST_ARMED, ST_POST: begin
          if (w_write) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            if (r_count != (AW+1)'(DEPTH)) r_count <= r_count + (AW+1)'(1);
            r_rr     <= w_rr_next;
            r_drop   <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
          end
          if (r_state == ST_ARMED) begin
            if (w_trig) begin
              if (POST_TRIG == 0) begin
                r_state <= ST_DONE;
              end else begin
                r_state    <= ST_POST;
                r_post_cnt <= AW'(POST_TRIG);
              end
            end
          end else if (w_write) begin
            r_post_cnt <= r_post_cnt - AW'(1);
            if (r_post_cnt == AW'(1)) r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (arm) begin
            r_state  <= ST_ARMED;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_drop   <= '0;
          end else if (rd_start) begin
            if (r_count == '0) begin
              r_state <= ST_IDLE;
            end else begin
              r_state  <= ST_READ;
              // Full buffer: low bits of DEPTH are zero, so oldest == wr_ptr.
              r_rd_ptr <= r_wr_ptr - r_count[AW-1:0];
              r_rd_rem <= r_count;
            end
          end
        end
        ST_READ: begin
          if (r_rd_vld && rd_ready && r_rd_last) begin
            r_state   <= ST_IDLE;
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
            r_count   <= '0;
          end else if ((!r_rd_vld || rd_ready) && (r_rd_rem != '0)) begin
            r_rd_data <= r_mem[r_rd_ptr];
            r_rd_vld  <= 1'b1;
            r_rd_last <= (r_rd_rem == (AW+1)'(1));
            r_rd_ptr  <= r_rd_ptr + AW'(1);
            r_rd_rem  <= r_rd_rem - (AW+1)'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rd_valid = r_rd_vld;
  assign rd_last  = r_rd_last;
  assign rd_data  = r_rd_data;
  assign state    = r_state;
  assign count    = r_count;
  assign drop_cnt = r_drop;

endmodule

// File: tb/tb_inst_trace_buffer.sv
// Bench for inst_trace_buffer: two instances (POST_TRIG=2 and POST_TRIG=0,
// DEPTH=8, NUM_CH=2) share stimulus and are compared every cycle against a
// queue-based model, plus literal expectations on drained entries.
module tb_inst_trace_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  ch_valid;
  logic [15:0] ch_warp;
  logic [63:0] ch_instr;
  logic [63:0] ch_pc;
  logic [7:0]  warp_mask;
  logic        arm, trig_in, trig_en, rd_start, rd_ready;
  logic [5:0]  trig_opcode, trig_opmask;

  logic [1:0]  d_rv, d_rl;
  logic [84:0] d_rd    [2];
  logic [2:0]  d_state [2];
  logic [3:0]  d_count [2];
  logic [15:0] d_drop  [2];

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  always #5 clk = ~clk;

  inst_trace_buffer #(.NUM_CH(2), .NUM_WARPS(8), .DEPTH(8), .POST_TRIG(2)) dut (
    .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid), .ch_warp_onehot(ch_warp),
    .ch_instr(ch_instr), .ch_pc(ch_pc), .warp_mask(warp_mask), .arm(arm),
    .trig_in(trig_in), .trig_en(trig_en), .trig_opcode(trig_opcode),
    .trig_opmask(trig_opmask), .rd_start(rd_start), .rd_valid(d_rv[0]),
    .rd_ready(rd_ready), .rd_data(d_rd[0]), .rd_last(d_rl[0]),
    .state(d_state[0]), .count(d_count[0]), .drop_cnt(d_drop[0]));

  inst_trace_buffer #(.NUM_CH(2), .NUM_WARPS(8), .DEPTH(8), .POST_TRIG(0)) dut_pt0 (
    .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid), .ch_warp_onehot(ch_warp),
    .ch_instr(ch_instr), .ch_pc(ch_pc), .warp_mask(warp_mask), .arm(arm),
    .trig_in(trig_in), .trig_en(trig_en), .trig_opcode(trig_opcode),
    .trig_opmask(trig_opmask), .rd_start(rd_start), .rd_valid(d_rv[1]),
    .rd_ready(rd_ready), .rd_data(d_rd[1]), .rd_last(d_rl[1]),
    .state(d_state[1]), .count(d_count[1]), .drop_cnt(d_drop[1]));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // States: 0 IDLE, 1 ARMED, 2 POST, 3 DONE, 4 READ.
  logic [84:0] m_q  [2][$];   // captured entries, oldest first
  logic [84:0] m_dq [2][$];   // entries still to present during a drain
  int          m_st [2];
  int          m_left [2];
  int          m_rr [2];
  int          m_drop [2];
  bit          m_rv [2];
  bit          m_rl [2];
  logic [84:0] m_rd [2];
  logic [15:0] m_ts;

  function automatic void present(input int k);
    m_rd[k] = m_dq[k].pop_front();
    m_rv[k] = 1'b1;
    m_rl[k] = (m_dq[k].size() == 0);
  endfunction

  function automatic void model_step(input int k);
    int pt;
    int nq;
    int win;
    bit wrote;
    bit trig;
    int wid;
    logic [7:0] oh;
    logic [31:0] ins;
    logic [84:0] e;
    pt  = (k == 0) ? 2 : 0;
    nq  = 0;
    win = -1;
    for (int i = 0; i < 2; i++) begin
      int c;
      c = (m_rr[k] + i) % 2;
      if (ch_valid[c] && ((ch_warp[c*8 +: 8] & warp_mask) != 0)) begin
        nq++;
        if (win < 0) win = c;
      end
    end
    case (m_st[k])
      0: if (arm) begin m_st[k] = 1; m_q[k].delete(); m_drop[k] = 0; end
      1, 2: begin
        wrote = (win >= 0);
        ins   = 0;
        if (wrote) begin
          oh  = ch_warp[win*8 +: 8];
          ins = ch_instr[win*32 +: 32];
          wid = 0;
          for (int b = 7; b >= 0; b--) if (oh[b]) wid = b;
          e = {1'($countones(oh) > 1), 1'(win), 3'(wid), m_ts, ch_pc[win*32 +: 32], ins};
          if (m_q[k].size() == 8) void'(m_q[k].pop_front());
          m_q[k].push_back(e);
          m_drop[k] = (m_drop[k] + nq - 1 > 65535) ? 65535 : m_drop[k] + nq - 1;
          m_rr[k] = (win + 1) % 2;
        end
        if (m_st[k] == 1) begin
          trig = trig_in || (wrote && trig_en && (((ins[31:26] ^ trig_opcode) & trig_opmask) == 0));
          if (trig) begin
            if (pt == 0) m_st[k] = 3;
            else begin m_st[k] = 2; m_left[k] = pt; end
          end
        end else if (wrote) begin
          m_left[k]--;
          if (m_left[k] == 0) m_st[k] = 3;
        end
      end
      3: begin
        if (arm) begin m_st[k] = 1; m_q[k].delete(); m_drop[k] = 0; end
        else if (rd_start) begin
          if (m_q[k].size() == 0) m_st[k] = 0;
          else begin m_dq[k] = m_q[k]; m_st[k] = 4; end
        end
      end
      4: begin
        if (m_rv[k] && rd_ready) begin
          if (m_rl[k]) begin
            m_st[k] = 0; m_rv[k] = 0; m_rl[k] = 0; m_q[k].delete();
          end else present(k);
        end else if (!m_rv[k]) present(k);
      end
      default: ;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_q[k].delete(); m_dq[k].delete();
        m_st[k] = 0; m_left[k] = 0; m_rr[k] = 0; m_drop[k] = 0;
        m_rv[k] = 0; m_rl[k] = 0; m_rd[k] = '0;
      end
      m_ts = '0;
    end else begin
      for (int k = 0; k < 2; k++) model_step(k);
      m_ts = m_ts + 16'd1;
    end
  end

  // ---------------- handshake capture / stall tracking ----------------
  logic [84:0] dr_q [2][$];
  bit          dl_q [2][$];
  bit          stall [2];
  logic [84:0] held  [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_n && d_rv[k] && rd_ready) begin
        dr_q[k].push_back(d_rd[k]);
        dl_q[k].push_back(d_rl[k]);
      end
      stall[k] = rst_n && d_rv[k] && !rd_ready;
      held[k]  = d_rd[k];
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("u%0d state", k), d_state[k], m_st[k]);
        chk($sformatf("u%0d count", k), d_count[k], m_q[k].size());
        chk($sformatf("u%0d drop_cnt", k), d_drop[k], m_drop[k]);
        chk($sformatf("u%0d rd_valid", k), d_rv[k], m_rv[k]);
        chk($sformatf("u%0d rd_last", k), d_rl[k], m_rl[k]);
        if (m_rv[k]) chk($sformatf("u%0d rd_data", k), d_rd[k], m_rd[k]);
        if (stall[k]) begin
          chk($sformatf("u%0d stall data", k), d_rd[k], held[k]);
          chk($sformatf("u%0d stall valid", k), d_rv[k], 1);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int unsigned ep [8];

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_in();
    ch_valid = '0; ch_warp = '0; ch_instr = '0; ch_pc = '0;
    arm = 0; trig_in = 0; rd_start = 0;
  endtask

  task automatic samp0(input logic [31:0] pc, input logic [31:0] ins,
                       input logic [7:0] oh, input bit trig);
    ch_valid = 2'b01; ch_warp = {8'h00, oh}; ch_pc = {32'h0, pc};
    ch_instr = {32'h0, ins}; trig_in = trig;
    tick();
    clr_in();
  endtask

  task automatic pulse_arm();
    arm = 1; tick(); arm = 0;
  endtask

  task automatic trig_only();
    trig_in = 1; tick(); trig_in = 0;
  endtask

  task automatic drain(input bit toggle);
    bit done;
    for (int k = 0; k < 2; k++) begin dr_q[k].delete(); dl_q[k].delete(); end
    rd_ready = 1;
    rd_start = 1; tick(); rd_start = 0;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (toggle) rd_ready = ~rd_ready;
      tick();
      done = (d_state[0] == 3'd0) && (d_state[1] == 3'd0);
    end
    chk("drain completes", done, 1);
    rd_ready = 1;
  endtask

  task automatic check_pcs(input int k, input string tag, input int n);
    chk({tag, " entries"}, dr_q[k].size(), n);
    for (int i = 0; i < n && i < dr_q[k].size(); i++) begin
      logic [84:0] e;
      e = dr_q[k][i];
      chk($sformatf("%s pc[%0d]", tag, i), e[63:32], ep[i]);
      chk($sformatf("%s last[%0d]", tag, i), dl_q[k][i], (i == n - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    int ech [6];
    logic [84:0] e;
    clr_in();
    rst_n = 0; warp_mask = 8'hFF; trig_en = 0; trig_opcode = 6'b100001;
    trig_opmask = 6'h3F; rd_ready = 1;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d reset state", k), d_state[k], 0);
      chk($sformatf("u%0d reset rd_valid", k), d_rv[k], 0);
      chk($sformatf("u%0d reset rd_last", k), d_rl[k], 0);
      chk($sformatf("u%0d reset rd_data", k), d_rd[k], 0);
      chk($sformatf("u%0d reset count", k), d_count[k], 0);
      chk($sformatf("u%0d reset drop", k), d_drop[k], 0);
    end
    rst_n = 1;
    chk_en = 1;
    tick();

    // Round-robin with both channels qualified; trigger without a write.
    pulse_arm();
    for (int i = 0; i < 4; i++) begin
      ch_valid = 2'b11; ch_warp = 16'h0101;
      ch_pc = {32'(300 + i), 32'(200 + i)};
      tick();
      clr_in();
    end
    chk("rr drop_cnt u0", d_drop[0], 4);
    chk("rr drop_cnt u1", d_drop[1], 4);
    trig_only();
    chk("trig no write u1 state", d_state[1], 3);
    chk("trig no write u0 state", d_state[0], 2);
    samp0(401, 0, 8'h01, 0);
    samp0(402, 0, 8'h01, 0);
    chk("rr count u0", d_count[0], 6);
    drain(0);
    ep = '{200, 301, 202, 303, 401, 402, 0, 0};
    check_pcs(0, "rr u0", 6);
    ep = '{200, 301, 202, 303, 0, 0, 0, 0};
    check_pcs(1, "rr u1", 4);
    ech = '{0, 1, 0, 1, 0, 0};
    for (int i = 0; i < 6 && i < dr_q[0].size(); i++) begin
      e = dr_q[0][i];
      chk($sformatf("rr ch_idx[%0d]", i), e[83], ech[i]);
    end

    // Basic capture: 3 samples, trigger on 4th, 2 post.
    pulse_arm();
    for (int n = 1; n <= 6; n++) samp0(32'(n), 0, 8'h01, n == 4);
    chk("basic u0 count", d_count[0], 6);
    chk("basic u1 count", d_count[1], 4);
    chk("basic u0 state", d_state[0], 3);
    drain(0);
    ep = '{1, 2, 3, 4, 5, 6, 0, 0};
    check_pcs(0, "basic u0", 6);
    ep = '{1, 2, 3, 4, 0, 0, 0, 0};
    check_pcs(1, "basic u1", 4);

    // Wrap: 20 samples, trigger on 18.
    pulse_arm();
    for (int n = 1; n <= 20; n++) samp0(32'(100 + n), 0, 8'h01, n == 18);
    chk("wrap u0 count", d_count[0], 8);
    chk("wrap u1 count", d_count[1], 8);
    drain(0);
    ep = '{113, 114, 115, 116, 117, 118, 119, 120};
    check_pcs(0, "wrap u0", 8);
    ep = '{111, 112, 113, 114, 115, 116, 117, 118};
    check_pcs(1, "wrap u1", 8);

    // Warp filter and multi-hot decoding.
    warp_mask = 8'h02;
    pulse_arm();
    samp0(499, 0, 8'h01, 0);
    chk("filter reject count", d_count[0], 0);
    samp0(500, 0, 8'h06, 0);
    trig_only();
    samp0(501, 0, 8'h02, 0);
    samp0(502, 0, 8'h02, 0);
    chk("filter u0 count", d_count[0], 3);
    chk("filter u1 count", d_count[1], 1);
    drain(0);
    ep = '{500, 501, 502, 0, 0, 0, 0, 0};
    check_pcs(0, "filter u0", 3);
    if (dr_q[1].size() > 0) begin
      e = dr_q[1][0];
      chk("filter warp_id", e[82:80], 1);
      chk("filter oh_err", e[84], 1);
      chk("filter pc", e[63:32], 500);
    end else chk("filter u1 entries", dr_q[1].size(), 1);
    warp_mask = 8'hFF;

    // Opcode trigger on EXIT, drain with stalling consumer.
    trig_en = 1;
    pulse_arm();
    samp0(600, 32'h0000_0007, 8'h01, 0);
    samp0(601, {6'b100001, 26'd5}, 8'h01, 0);
    chk("opcode u1 state", d_state[1], 3);
    chk("opcode u0 state", d_state[0], 2);
    samp0(602, 0, 8'h01, 0);
    samp0(603, 0, 8'h01, 0);
    chk("opcode u0 count", d_count[0], 4);
    drain(1);
    ep = '{600, 601, 602, 603, 0, 0, 0, 0};
    check_pcs(0, "opcode u0", 4);
    ep = '{600, 601, 0, 0, 0, 0, 0, 0};
    check_pcs(1, "opcode u1", 2);
    trig_en = 0;

    // Reset in the middle of a drain.
    pulse_arm();
    for (int n = 1; n <= 6; n++) samp0(32'(700 + n), 0, 8'h01, n == 4);
    rd_ready = 0;
    rd_start = 1; tick(); rd_start = 0;
    tick();
    chk("pre-reset rd_valid", d_rv, 2'b11);
    #2 rst_n = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d midreset rd_valid", k), d_rv[k], 0);
      chk($sformatf("u%0d midreset state", k), d_state[k], 0);
      chk($sformatf("u%0d midreset count", k), d_count[k], 0);
    end
    tick();
    rst_n = 1; rd_ready = 1;
    tick();

    // Empty drain, and arm beating rd_start.
    pulse_arm();
    trig_only();
    chk("empty u1 state", d_state[1], 3);
    chk("empty u1 count", d_count[1], 0);
    rd_start = 1; tick(); rd_start = 0;
    chk("empty drain u1 state", d_state[1], 0);
    repeat (2) tick();
    samp0(801, 0, 8'h01, 0);
    samp0(802, 0, 8'h01, 0);
    chk("arm-vs-read pre u0 state", d_state[0], 3);
    arm = 1; rd_start = 1; tick(); arm = 0; rd_start = 0;
    chk("arm wins u0 state", d_state[0], 1);
    chk("arm wins u0 count", d_count[0], 0);
    tick();

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
